// File: rtl/mar_pkg.sv
// Shared types and default widths for the wide memory address register.
package mar_pkg;

    typedef enum logic {
        MAR_IDLE,
        MAR_LOADING
    } mar_state_t;

    localparam int MAR_ADDR_W = 16;
    localparam int MAR_BUS_W  = 8;

endpackage

// File: rtl/mar_wide.sv
// Memory address register assembled LSB-first from narrow bus beats.
// Optional auto-increment of the committed address is enabled by MAR_AUTOINC_EN.
module mar_wide
    import mar_pkg::*;
#(
    parameter int ADDR_W = MAR_ADDR_W,
    parameter int BUS_W  = MAR_BUS_W
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [BUS_W-1:0]  W_bus,
    input  logic              Lm_bar,
    input  logic              INC,
    output logic [ADDR_W-1:0] ROM_address,
    output logic              busy,
    output logic              load_done
);

    localparam int NBEATS = ADDR_W / BUS_W;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    generate
        if (ADDR_W % BUS_W != 0) begin : g_bad_width
            $error("mar_wide: ADDR_W must be an integer multiple of BUS_W");
        end
    endgenerate

    mar_state_t        state, state_next;
    logic [BEAT_W-1:0] beat, beat_next;
    logic [BEAT_W-1:0] capture_idx;
    logic [ADDR_W-1:0] staging, staging_next;
    logic [ADDR_W-1:0] assembled;
    logic              capture;
    logic              commit;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values, independent of process ordering.
    always_ff @(posedge CLK) begin
        // NOTE: reset is synchronous; CLR is only seen on a rising edge.
        if (CLR) begin
            state <= MAR_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A sequence always starts at chunk 0 from IDLE, so a fresh load never
    // inherits bits from an earlier one.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next   = state;
        beat_next    = beat;
        staging_next = staging;
        capture      = ~Lm_bar;
        capture_idx  = (state == MAR_IDLE) ? '0 : beat;
        assembled    = (state == MAR_IDLE) ? '0 : staging;
        assembled[int'(capture_idx) * BUS_W +: BUS_W] = W_bus;
        commit       = capture && (capture_idx == LAST_BEAT);

        case (state)
            MAR_IDLE: begin
                if (capture && !commit) begin
                    state_next   = MAR_LOADING;
                    beat_next    = BEAT_W'(1);
                    staging_next = assembled;
                end
            end
            MAR_LOADING: begin
                if (!capture || commit) begin
                    // Abort and commit both leave nothing staged.
                    state_next   = MAR_IDLE;
                    beat_next    = '0;
                    staging_next = '0;
                end else begin
                    beat_next    = beat + 1'b1;
                    staging_next = assembled;
                end
            end
            default: begin
                state_next   = MAR_IDLE;
                beat_next    = '0;
                staging_next = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state == MAR_LOADING);
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            beat        <= '0;
            staging     <= '0;
            ROM_address <= '0;
            load_done   <= 1'b0;
        end else begin
            beat      <= beat_next;
            staging   <= staging_next;
            load_done <= commit;
            if (commit) begin
                ROM_address <= assembled;
`ifdef MAR_AUTOINC_EN
            end else if (INC) begin
                ROM_address <= ROM_address + 1'b1;
`endif
            end
        end
    end

`ifndef MAR_AUTOINC_EN
    logic unused_inc;
    assign unused_inc = INC;
`endif

endmodule

// File: tb/tb_mar_wide.sv
// Directed self-checking bench for mar_wide at ADDR_W=16, BUS_W=8.
module tb_mar_wide;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [7:0]  W_bus;
    logic        Lm_bar;
    logic        INC;
    logic [15:0] ROM_address;
    logic        busy;
    logic        load_done;

    int passed = 0;
    int total  = 0;

    mar_wide #(.ADDR_W(16), .BUS_W(8)) dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .W_bus       (W_bus),
        .Lm_bar      (Lm_bar),
        .INC         (INC),
        .ROM_address (ROM_address),
        .busy        (busy),
        .load_done   (load_done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Apply inputs on the falling edge, then sample 1 ns after the rising edge.
    task automatic step(input logic clr, input logic lm_bar, input logic [7:0] w, input logic inc);
        @(negedge CLK);
        CLR    = clr;
        Lm_bar = lm_bar;
        W_bus  = w;
        INC    = inc;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [15:0] addr, input logic b, input logic d);
        check({tag, ".addr"}, ROM_address, addr);
        check({tag, ".busy"}, {15'd0, busy}, {15'd0, b});
        check({tag, ".done"}, {15'd0, load_done}, {15'd0, d});
    endtask

    logic autoinc;

    initial begin
`ifdef MAR_AUTOINC_EN
        autoinc = 1'b1;
`else
        autoinc = 1'b0;
`endif
        CLR = 1'b1; Lm_bar = 1'b1; W_bus = 8'h00; INC = 1'b0;

        step(1, 1, 8'h00, 0);
        check_out("reset", 16'h0000, 0, 0);

        // Basic two-beat load.
        step(0, 0, 8'h34, 0);
        check_out("s1_beat1", 16'h0000, 1, 0);
        step(0, 0, 8'h12, 0);
        check_out("s1_commit", 16'h1234, 0, 1);
        step(0, 1, 8'h00, 0);
        check_out("s1_idle", 16'h1234, 0, 0);

        // Abort after one beat.
        step(0, 0, 8'hAA, 0);
        check_out("s2_beat1", 16'h1234, 1, 0);
        step(0, 1, 8'h00, 0);
        check_out("s2_abort", 16'h1234, 0, 0);
        step(0, 1, 8'h00, 0);
        check_out("s2_after", 16'h1234, 0, 0);

        // Load all-ones, then increment across the wrap.
        step(0, 0, 8'hFF, 0);
        step(0, 0, 8'hFF, 0);
        check_out("s3_load", 16'hFFFF, 0, 1);
        step(0, 1, 8'h00, 1);
        check_out("s3_inc1", autoinc ? 16'h0000 : 16'hFFFF, 0, 0);
        step(0, 1, 8'h00, 1);
        check_out("s3_inc2", autoinc ? 16'h0001 : 16'hFFFF, 0, 0);

        // INC while loading bumps the committed value; INC on commit is dropped.
        step(0, 0, 8'h00, 1);
        check_out("s4_beat1", autoinc ? 16'h0002 : 16'hFFFF, 1, 0);
        step(0, 0, 8'h01, 1);
        check_out("s4_commit", 16'h0100, 0, 1);

        // Reset in the middle of a load.
        step(0, 0, 8'h55, 0);
        check_out("s5_beat1", 16'h0100, 1, 0);
        step(1, 0, 8'h66, 1);
        check_out("s5_clr", 16'h0000, 0, 0);
        step(0, 0, 8'h78, 0);
        check_out("s5_beat1b", 16'h0000, 1, 0);
        step(0, 0, 8'h56, 0);
        check_out("s5_commit", 16'h5678, 0, 1);

        // Back-to-back loads with Lm_bar held low.
        step(0, 1, 8'h00, 0);
        check_out("s6_gap", 16'h5678, 0, 0);
        step(0, 0, 8'h01, 0);
        check_out("s6_e1", 16'h5678, 1, 0);
        step(0, 0, 8'h02, 0);
        check_out("s6_e2", 16'h0201, 0, 1);
        step(0, 0, 8'h03, 0);
        check_out("s6_e3", 16'h0201, 1, 0);
        step(0, 0, 8'h04, 0);
        check_out("s6_e4", 16'h0403, 0, 1);
        step(0, 1, 8'h00, 0);
        check_out("s6_idle", 16'h0403, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mar_wide.md
MAR_WIDE -- requirements
Module: mar_wide

Interface
REQ-001 Parameter ADDR_W, default 16, committed address width in bits.
REQ-002 Parameter BUS_W, default 8, width of the bus chunk captured per load beat; ADDR_W SHALL be an integer multiple of BUS_W, with NBEATS = ADDR_W/BUS_W.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 CLR  input  1  reset, synchronous and active-high.
REQ-005 W_bus  input  BUS_W  bus chunk to capture during a load beat.
REQ-006 Lm_bar  input  1  load enable, active-low.
REQ-007 INC  input  1  increment committed address, active-high.
REQ-008 ROM_address  output  ADDR_W  committed address to memory, registered.
REQ-009 busy  output  1  high while a multi-beat load is partially captured.
REQ-010 load_done  output  1  one-cycle pulse after an address commit.

Function
REQ-011 States: IDLE and LOADING; a beat counter (0..NBEATS-1) and an ADDR_W staging register SHALL be kept.
REQ-012 IDLE: an edge with Lm_bar=0 SHALL capture W_bus into staging chunk 0 (LSBs) and move to LOADING with beat=1; if NBEATS=1 it SHALL commit at that edge and stay in IDLE.
REQ-013 LOADING: each edge with Lm_bar=0 SHALL capture W_bus into chunk[beat], LSB-first, and increment beat.
REQ-014 The edge capturing chunk NBEATS-1 SHALL write the full assembled address to ROM_address at that same edge, return to IDLE, and clear beat.
REQ-015 ROM_address SHALL never show a partially loaded address; it changes only on commit, on increment, or on reset.
REQ-016 Lm_bar=1 in LOADING SHALL abort: staging discarded, state to IDLE, ROM_address unchanged, no load_done.
REQ-017 Lm_bar held low past the final beat SHALL start a new sequence on the next edge (back-to-back loads, no idle cycle).
REQ-018 load_done SHALL be 1 for exactly the cycle following a commit edge, else 0.
REQ-019 busy SHALL equal (state==LOADING).
REQ-020 INC=1 on an edge without commit SHALL set ROM_address to ROM_address+1 mod 2^ADDR_W; all-ones wraps to 0.
REQ-021 INC and commit on the same edge: the commit SHALL win and INC is dropped.
REQ-022 INC during LOADING without commit SHALL increment the committed address; staging is unaffected.

Reset
REQ-023 CLR=1 at an edge SHALL force ROM_address=0, staging=0, beat=0, state=IDLE, load_done=0, busy=0, overriding all other inputs, including mid-sequence.
REQ-024 The first edge with CLR=0 SHALL process Lm_bar and INC normally.

Configuration
REQ-025 Macro MAR_AUTOINC_EN: when defined, INC behaves per REQ-020..022.
REQ-026 Without MAR_AUTOINC_EN, the INC port SHALL remain present but be ignored, and no incrementer logic SHALL be synthesised.

Structure
REQ-027 Package mar_pkg SHALL hold the state enum (MAR_IDLE, MAR_LOADING) and the default ADDR_W and BUS_W constants.
REQ-028 No sub-module; the beat counter, staging register and commit logic SHALL live in mar_wide.
REQ-029 Elaboration SHALL fail if ADDR_W % BUS_W != 0.

Verification (ADDR_W=16, BUS_W=8)
REQ-030 Scenario 1, basic load: CLR, then Lm_bar=0 for 2 edges with W_bus=0x34 then 0x12 -> busy=1 after edge 1, ROM_address=0x1234 after edge 2, load_done=1 for one cycle, and ROM_address stays 0 after edge 1.
REQ-031 Scenario 2, abort: ROM_address=0x1234, Lm_bar=0 for 1 edge with 0xAA, then Lm_bar=1 -> busy=0, ROM_address=0x1234, no load_done.
REQ-032 Scenario 3, increment and wrap: load 0xFFFF, then INC=1 for 2 edges -> 0x0000, then 0x0001 (macro on); with the macro off, the value stays 0xFFFF.
REQ-033 Scenario 4, collision: INC=1 on the commit edge of a load of 0x0100 -> ROM_address=0x0100, not 0x0101.
REQ-034 Scenario 5, reset mid-load: Lm_bar=0 with 0x55, then CLR=1 -> all outputs 0, state IDLE; a following 2-beat load of 0x78, 0x56 gives 0x5678.
REQ-035 Scenario 6, back-to-back: Lm_bar held low for 4 edges with 0x01, 0x02, 0x03, 0x04 -> 0x0201 after edge 2 and 0x0403 after edge 4, with two load_done pulses.
